primitive_fetcher: RTL and testbench
====================================

Name: primitive_fetcher

Overview:
- Parametrised successor to the triangle fetch stage. Reads one primitive of 1..MAX_VERTS vertices from the primitive FIFO and writes each vertex's attribute words into per-vertex attribute memories.
- Captures each vertex's position words, then presents the primitive to the cull stage with a valid/ready handshake.
- Honours FIFO empty (1-cycle read latency), enable stalls and abort.

Parameters:
- DATA_WIDTH, 32, width of one FIFO/attribute word
- ADDR_WIDTH, 4, attribute memory address width; max words per vertex = 2^ADDR_WIDTH
- MAX_VERTS, 3, number of vertex lanes (attribute memories / position outputs)
- POS_WORDS, 2, leading words of each vertex captured as position

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- en  in  1  stall when low; no new FIFO reads issued
- abort  in  1  synchronous abort of current primitive
- start_fetch  in  1  start one primitive fetch (sampled only in IDLE)
- verts_per_prim  in  $clog2(MAX_VERTS+1)  vertex count, sampled with start_fetch
- vertex_size  in  ADDR_WIDTH  index of last word per vertex (words/vertex = vertex_size+1), sampled with start_fetch
- fifo_rd_data  in  DATA_WIDTH  FIFO read data, valid 1 cycle after fifo_rd_en
- fifo_empty  in  1  FIFO empty flag
- fifo_rd_en  out  1  FIFO read strobe
- vert_attr_wr_data  out  MAX_VERTS*DATA_WIDTH  per-lane write data (lane k at [k*DATA_WIDTH +: DATA_WIDTH])
- vert_attr_wr_addr  out  MAX_VERTS*ADDR_WIDTH  per-lane write address
- vert_attr_wr_en  out  MAX_VERTS  one-hot lane write enable
- pos_out  out  MAX_VERTS*POS_WORDS*DATA_WIDTH  captured positions; word 0 of a vertex occupies the MS word of that vertex's slice
- prim_valid  out  1  primitive complete, held until prim_ready
- prim_ready  in  1  cull stage accepts primitive
- prim_nverts  out  $clog2(MAX_VERTS+1)  latched vertex count of presented primitive
- busy  out  1  high in any state except IDLE

Behaviour:
- Reset: all outputs 0, state IDLE, all counters 0.
- States:
  - IDLE: on start_fetch, latch verts_per_prim and vertex_size, clear pos_out, go FETCH. verts_per_prim of 0 or >MAX_VERTS latches as MAX_VERTS.
  - FETCH: issue reads; go DRAIN after the last read is issued.
  - DRAIN: wait for the last word to arrive, then go HOLD.
  - HOLD: prim_valid=1; on prim_ready go IDLE.
- Total words = nverts*(vertex_size+1).
- fifo_rd_en is combinational from registered state: fifo_rd_en = (state==FETCH) & en & !fifo_empty & !abort.
- Data for a read issued in cycle t is captured at the end of cycle t+1 (in-flight flag). Captures are never blocked by en.
- Arrival counters: word w (0..vertex_size) and lane v (0..nverts-1).
- On each arrival, registered one cycle later:
  - vert_attr_wr_en = 1<<v
  - lane v addr = w
  - lane v data = word
  - if w<POS_WORDS, the position word is stored.
  - w wraps to 0 after vertex_size, then v increments.
- vert_attr_wr_en is 0 in any cycle without an arrival. Non-selected lanes hold their last data/address.
- Issued-read count is tracked separately. The FETCH->DRAIN transition occurs when issued count reaches total.
- HOLD is entered the cycle after the final write is registered, so all attribute writes complete before prim_valid.
- If vertex_size < POS_WORDS-1, the uncaptured position words stay 0.
- prim_valid and prim_nverts are stable while prim_valid=1 && !prim_ready. prim_valid drops the cycle after the handshake.
- start_fetch outside IDLE is ignored (no queueing).
- abort (any non-IDLE state): next cycle state=IDLE, counters cleared, prim_valid=0, wr_en=0. Any in-flight word is discarded (not written). fifo_rd_en is 0 in the abort cycle. abort has priority over start_fetch and prim_ready.
- fifo_empty mid-fetch: reads pause with no wr_en gaps beyond the data gaps, and resume when non-empty.
- Reset mid-operation returns all state to reset values immediately.

Test Plan:
- Triangle, vertex_size=3, FIFO prefilled with words 0..11: 12 consecutive rd_en cycles; lane writes 0..3 go to lanes 0,1,2 in turn. pos_out gives vertex0 = {0,1}, vertex1 = {4,5}, vertex2 = {8,9}. prim_valid appears 2 cycles after the last rd_en, prim_nverts=3.
- Line, verts_per_prim=2, vertex_size=1: exactly 4 reads; lane2 wr_en never asserts; lane2 pos_out=0.
- fifo_empty toggles every other cycle during a triangle fetch: still exactly 3*(vertex_size+1) reads; data order preserved; no read issued while empty.
- prim_ready held low 5 cycles: prim_valid held 5 cycles with pos_out stable. start_fetch pulsed during HOLD is ignored; no extra reads.
- abort asserted the cycle after the 5th read: no write for the 5th word; next cycle IDLE with busy=0 and prim_valid never asserted. A new start_fetch then fetches normally.
- en low for 3 cycles mid-fetch: rd_en=0 during those cycles; the outstanding word is still written; the total read count is unchanged.

Source files
------------

// File: rtl/primitive_fetcher.sv
// Primitive fetch stage: streams 1..MAX_VERTS vertices from the primitive FIFO
// into per-lane attribute memories, captures position words and hands the
// finished primitive to the cull stage over a valid/ready handshake.
module primitive_fetcher #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 4,
   parameter int unsigned MAX_VERTS  = 3,
   parameter int unsigned POS_WORDS  = 2
) (
   input  logic                                   clk,
   input  logic                                   resetn,
   input  logic                                   en,
   input  logic                                   abort,
   input  logic                                   start_fetch,
   input  logic [$clog2(MAX_VERTS+1)-1:0]         verts_per_prim,
   input  logic [ADDR_WIDTH-1:0]                  vertex_size,
   input  logic [DATA_WIDTH-1:0]                  fifo_rd_data,
   input  logic                                   fifo_empty,
   output logic                                   fifo_rd_en,
   output logic [MAX_VERTS*DATA_WIDTH-1:0]        vert_attr_wr_data,
   output logic [MAX_VERTS*ADDR_WIDTH-1:0]        vert_attr_wr_addr,
   output logic [MAX_VERTS-1:0]                   vert_attr_wr_en,
   output logic [MAX_VERTS*POS_WORDS*DATA_WIDTH-1:0] pos_out,
   output logic                                   prim_valid,
   input  logic                                   prim_ready,
   output logic [$clog2(MAX_VERTS+1)-1:0]         prim_nverts,
   output logic                                   busy
);

   localparam int unsigned NV_W  = $clog2(MAX_VERTS + 1);
   localparam int unsigned CNT_W = $clog2(MAX_VERTS * (2 ** ADDR_WIDTH) + 1);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_FETCH = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;
   localparam logic [1:0] ST_HOLD  = 2'd3;

   logic [1:0]            state_q;
   logic [1:0]            state_nxt;
   logic [ADDR_WIDTH-1:0] vsize_q;
   logic [CNT_W-1:0]      issued_q;
   logic [ADDR_WIDTH-1:0] word_q;
   logic [NV_W-1:0]       lane_q;
   logic                  inflight_q;

   logic [CNT_W-1:0]      total_c;
   logic [NV_W-1:0]       nv_sel_c;
   logic                  start_c;
   logic                  arrive_c;
   logic                  last_issue_c;
   logic                  last_arrival_c;

   // Next-state decode, read strobe and arrival bookkeeping
   always_comb begin
      state_nxt      = state_q;
      total_c        = CNT_W'(prim_nverts) * (CNT_W'(vsize_q) + CNT_W'(1));
      nv_sel_c       = verts_per_prim;
      start_c        = 1'b0;
      fifo_rd_en     = 1'b0;
      arrive_c       = 1'b0;
      last_issue_c   = 1'b0;
      last_arrival_c = 1'b0;

      if (verts_per_prim == '0 || verts_per_prim > NV_W'(MAX_VERTS))
         nv_sel_c = NV_W'(MAX_VERTS);

      start_c        = (state_q == ST_IDLE) && start_fetch && !abort;
      fifo_rd_en     = (state_q == ST_FETCH) && en && !fifo_empty && !abort;
      arrive_c       = inflight_q && !abort;
      last_issue_c   = fifo_rd_en && (issued_q == total_c - CNT_W'(1));
      last_arrival_c = arrive_c && (word_q == vsize_q) &&
                       (lane_q == prim_nverts - NV_W'(1));

      case (state_q)
         ST_IDLE:  if (start_c)        state_nxt = ST_FETCH;
         ST_FETCH: if (last_issue_c)   state_nxt = ST_DRAIN;
         ST_DRAIN: if (last_arrival_c) state_nxt = ST_HOLD;
         ST_HOLD:  if (prim_ready)     state_nxt = ST_IDLE;
         default:                      state_nxt = ST_IDLE;
      endcase

      if (abort)
         state_nxt = ST_IDLE;
   end

   // State register
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state_q <= ST_IDLE;
      else         state_q <= state_nxt;
   end

   // Counters, lane writes, position capture and handshake outputs
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         vsize_q           <= '0;
         issued_q          <= '0;
         word_q            <= '0;
         lane_q            <= '0;
         inflight_q        <= 1'b0;
         vert_attr_wr_data <= '0;
         vert_attr_wr_addr <= '0;
         vert_attr_wr_en   <= '0;
         pos_out           <= '0;
         prim_valid        <= 1'b0;
         prim_nverts       <= '0;
         busy              <= 1'b0;
      end else begin
         inflight_q      <= fifo_rd_en;
         prim_valid      <= (state_nxt == ST_HOLD);
         busy            <= (state_nxt != ST_IDLE);
         vert_attr_wr_en <= '0;

         if (abort) begin
            issued_q <= '0;
            word_q   <= '0;
            lane_q   <= '0;
         end else begin
            if (start_c) begin
               prim_nverts <= nv_sel_c;
               vsize_q     <= vertex_size;
               pos_out     <= '0;
               issued_q    <= '0;
               word_q      <= '0;
               lane_q      <= '0;
            end

            if (fifo_rd_en)
               issued_q <= issued_q + CNT_W'(1);

            if (arrive_c) begin
               for (int unsigned k = 0; k < MAX_VERTS; k++) begin
                  if (lane_q == NV_W'(k)) begin
                     vert_attr_wr_en[k]                              <= 1'b1;
                     vert_attr_wr_data[k*DATA_WIDTH +: DATA_WIDTH]   <= fifo_rd_data;
                     vert_attr_wr_addr[k*ADDR_WIDTH +: ADDR_WIDTH]   <= word_q;
                     // word 0 of a vertex lands in the most significant slot
                     for (int unsigned p = 0; p < POS_WORDS; p++) begin
                        if (word_q == ADDR_WIDTH'(p))
                           pos_out[(k*POS_WORDS + POS_WORDS - 1 - p)*DATA_WIDTH +: DATA_WIDTH]
                              <= fifo_rd_data;
                     end
                  end
               end

               if (word_q == vsize_q) begin
                  word_q <= '0;
                  lane_q <= lane_q + NV_W'(1);
               end else begin
                  word_q <= word_q + ADDR_WIDTH'(1);
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_primitive_fetcher.sv
// Scoreboard bench for primitive_fetcher: directed primitives are fed through
// a 1-cycle-latency FIFO model; expected lane writes and primitives are queued
// at issue time and checked by an independent monitor.
module tb_primitive_fetcher;

   localparam int DW  = 32;
   localparam int AW  = 4;
   localparam int MV  = 3;
   localparam int PW  = 2;
   localparam int NVW = 2;

   typedef struct {
      int          lane;
      int          addr;
      logic [31:0] data;
   } wr_t;

   typedef struct {
      int                    nv;
      logic [MV*PW*DW-1:0]   pos;
   } prim_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                  resetn, en, abort, start_fetch;
   logic [NVW-1:0]        verts_per_prim;
   logic [AW-1:0]         vertex_size;
   logic [DW-1:0]         fifo_rd_data = '0;
   logic                  fifo_empty, fifo_rd_en;
   logic [MV*DW-1:0]      wr_data;
   logic [MV*AW-1:0]      wr_addr;
   logic [MV-1:0]         wr_en;
   logic [MV*PW*DW-1:0]   pos_out;
   logic                  prim_valid, prim_ready, busy;
   logic [NVW-1:0]        prim_nverts;

   primitive_fetcher dut (
      .clk               (clk),
      .resetn            (resetn),
      .en                (en),
      .abort             (abort),
      .start_fetch       (start_fetch),
      .verts_per_prim    (verts_per_prim),
      .vertex_size       (vertex_size),
      .fifo_rd_data      (fifo_rd_data),
      .fifo_empty        (fifo_empty),
      .fifo_rd_en        (fifo_rd_en),
      .vert_attr_wr_data (wr_data),
      .vert_attr_wr_addr (wr_addr),
      .vert_attr_wr_en   (wr_en),
      .pos_out           (pos_out),
      .prim_valid        (prim_valid),
      .prim_ready        (prim_ready),
      .prim_nverts       (prim_nverts),
      .busy              (busy)
   );

   int n_vec  = 0;
   int n_miss = 0;

   wr_t   exp_wr[$];
   prim_t exp_prim[$];

   // FIFO model
   logic [DW-1:0] mem [0:255];
   int   wr_ptr = 0;
   int   rd_ptr = 0;
   int   rd_cnt = 0;
   int   bad_rd = 0;
   int   cyc = 0;
   int   last_rd_cyc = 0;
   int   lane2_cnt = 0;
   logic gate = 1'b0;
   logic tog  = 1'b0;

   assign fifo_empty = (rd_ptr == wr_ptr) || gate;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (fifo_rd_en) begin
         if (fifo_empty) bad_rd <= bad_rd + 1;
         else begin
            fifo_rd_data <= mem[rd_ptr];
            rd_ptr       <= rd_ptr + 1;
         end
         rd_cnt      <= rd_cnt + 1;
         last_rd_cyc <= cyc;
      end
   end

   always @(negedge clk) gate <= tog ? ~gate : 1'b0;

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: pops expectations whenever the DUT writes or hands off a primitive
   always @(negedge clk) begin
      if (resetn) begin
         if (wr_en != '0) begin
            if (wr_en[2]) lane2_cnt <= lane2_cnt + 1;
            if (exp_wr.size() == 0) check("unexpected_wr", 256'(wr_en), 256'(0));
            else begin
               wr_t         e;
               logic [MV-1:0] oh;
               e  = exp_wr.pop_front();
               oh = 3'b001 << e.lane;
               check("wr_en",   256'(wr_en), 256'(oh));
               check("wr_addr", 256'(wr_addr[e.lane*AW +: AW]), 256'(e.addr));
               check("wr_data", 256'(wr_data[e.lane*DW +: DW]), 256'(e.data));
            end
         end
         if (prim_valid && prim_ready) begin
            if (exp_prim.size() == 0) check("unexpected_prim", 256'(prim_valid), 256'(0));
            else begin
               prim_t p;
               p = exp_prim.pop_front();
               check("prim_nverts", 256'(prim_nverts), 256'(p.nv));
               check("pos_out",     256'(pos_out), 256'(p.pos));
            end
         end
      end
   end

   task automatic fill(input int base, input int n);
      for (int i = 0; i < n; i++) begin
         mem[wr_ptr] = DW'(base + i);
         wr_ptr++;
      end
   endtask

   task automatic push_wr(input int lane, input int addr, input int data);
      wr_t e;
      e.lane = lane; e.addr = addr; e.data = 32'(data);
      exp_wr.push_back(e);
   endtask

   task automatic push_writes(input int n, input int vs, input int base);
      for (int v = 0; v < n; v++)
         for (int w = 0; w <= vs; w++)
            push_wr(v, w, base + v*(vs+1) + w);
   endtask

   task automatic push_prim(input int nv, input logic [MV*PW*DW-1:0] pos);
      prim_t p;
      p.nv = nv; p.pos = pos;
      exp_prim.push_back(p);
   endtask

   task automatic run_start(input int n, input int vs, output int s);
      @(posedge clk); #1;
      start_fetch = 1'b1;
      verts_per_prim = NVW'(n);
      vertex_size = AW'(vs);
      s = cyc;
      @(posedge clk); #1;
      start_fetch = 1'b0;
   endtask

   task automatic wait_valid(input int budget, output int vc);
      vc = -1;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (prim_valid) begin vc = cyc; break; end
      end
      check("valid_timeout", 256'(prim_valid), 256'(1));
   endtask

   task automatic settle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int s, vc, mark, l2;
      resetn = 1'b0; en = 1'b1; abort = 1'b0; start_fetch = 1'b0;
      verts_per_prim = '0; vertex_size = '0; prim_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 resetn = 1'b1;
      @(negedge clk);
      check("rst_prim_valid", 256'(prim_valid), 256'(0));
      check("rst_busy",       256'(busy), 256'(0));
      check("rst_wr_en",      256'(wr_en), 256'(0));
      check("rst_wr_addr",    256'(wr_addr), 256'(0));
      check("rst_wr_data",    256'(wr_data), 256'(0));
      check("rst_pos",        256'(pos_out), 256'(0));
      check("rst_nverts",     256'(prim_nverts), 256'(0));
      check("rst_rd_en",      256'(fifo_rd_en), 256'(0));

      // Triangle via verts_per_prim=0 (latches as 3), vertex_size=3, words 0..11
      fill(0, 12);
      push_writes(3, 3, 0);
      push_prim(3, {32'd8, 32'd9, 32'd4, 32'd5, 32'd0, 32'd1});
      mark = rd_cnt;
      run_start(0, 3, s);
      wait_valid(60, vc);
      check("tri_reads",     256'(rd_cnt - mark), 256'(12));
      check("tri_rd_window", 256'(last_rd_cyc - s), 256'(12));
      check("tri_valid_lat", 256'(vc - last_rd_cyc), 256'(2));
      settle(2);
      check("tri_busy_done", 256'(busy), 256'(0));

      // Line: 2 vertices, vertex_size=1
      fill(100, 4);
      push_writes(2, 1, 100);
      push_prim(2, {32'd0, 32'd0, 32'd102, 32'd103, 32'd100, 32'd101});
      mark = rd_cnt; l2 = lane2_cnt;
      run_start(2, 1, s);
      wait_valid(60, vc);
      check("line_reads", 256'(rd_cnt - mark), 256'(4));
      settle(2);
      check("line_lane2_wr", 256'(lane2_cnt - l2), 256'(0));

      // FIFO empty toggling every other cycle during a triangle fetch
      fill(200, 9);
      push_writes(3, 2, 200);
      push_prim(3, {32'd206, 32'd207, 32'd203, 32'd204, 32'd200, 32'd201});
      mark = rd_cnt;
      tog = 1'b1;
      run_start(3, 2, s);
      wait_valid(100, vc);
      tog = 1'b0;
      check("empty_reads",  256'(rd_cnt - mark), 256'(9));
      check("empty_bad_rd", 256'(bad_rd), 256'(0));
      settle(2);

      // Backpressure: prim_ready low for 5 valid cycles, start_fetch in HOLD ignored
      prim_ready = 1'b0;
      fill(300, 6);
      push_writes(3, 1, 300);
      push_prim(3, {32'd304, 32'd305, 32'd302, 32'd303, 32'd300, 32'd301});
      mark = rd_cnt;
      run_start(3, 1, s);
      wait_valid(60, vc);
      for (int i = 1; i < 5; i++) begin
         @(posedge clk); #1;
         start_fetch = (i == 2);
         verts_per_prim = 2'd1;
         @(negedge clk);
         check("hold_valid", 256'(prim_valid), 256'(1));
         check("hold_pos", 256'(pos_out),
               256'({32'd304, 32'd305, 32'd302, 32'd303, 32'd300, 32'd301}));
      end
      @(posedge clk); #1;
      start_fetch = 1'b0;
      prim_ready  = 1'b1;
      @(negedge clk);
      settle(3);
      @(negedge clk);
      check("hold_valid_drop", 256'(prim_valid), 256'(0));
      check("hold_busy_done",  256'(busy), 256'(0));
      check("hold_reads",      256'(rd_cnt - mark), 256'(6));

      // Abort the cycle after the 5th read; 5th word must not be written
      fill(400, 6);
      for (int w = 0; w < 4; w++) push_wr(0, w, 400 + w);
      mark = rd_cnt;
      run_start(3, 3, s);
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (fifo_rd_en && (rd_cnt - mark) == 4) break;
      end
      @(posedge clk); #1;
      abort = 1'b1;
      @(negedge clk);
      check("abort_rd_en", 256'(fifo_rd_en), 256'(0));
      check("abort_busy_in", 256'(busy), 256'(1));
      @(posedge clk); #1;
      abort = 1'b0;
      @(negedge clk);
      check("abort_busy",  256'(busy), 256'(0));
      check("abort_wr_en", 256'(wr_en), 256'(0));
      check("abort_valid", 256'(prim_valid), 256'(0));
      check("abort_reads", 256'(rd_cnt - mark), 256'(5));
      // Restart reads the leftover word 405 first
      fill(406, 3);
      push_writes(2, 1, 405);
      push_prim(2, {32'd0, 32'd0, 32'd407, 32'd408, 32'd405, 32'd406});
      mark = rd_cnt;
      run_start(2, 1, s);
      wait_valid(60, vc);
      check("restart_reads", 256'(rd_cnt - mark), 256'(4));
      settle(2);

      // en low for 3 cycles mid-fetch
      fill(600, 6);
      push_writes(3, 1, 600);
      push_prim(3, {32'd604, 32'd605, 32'd602, 32'd603, 32'd600, 32'd601});
      mark = rd_cnt;
      run_start(3, 1, s);
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (fifo_rd_en && (rd_cnt - mark) == 1) break;
      end
      @(posedge clk); #1;
      en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("stall_rd_en", 256'(fifo_rd_en), 256'(0));
         @(posedge clk); #1;
      end
      en = 1'b1;
      wait_valid(60, vc);
      check("stall_reads", 256'(rd_cnt - mark), 256'(6));
      settle(3);

      check("sb_wr_left",   256'(exp_wr.size()), 256'(0));
      check("sb_prim_left", 256'(exp_prim.size()), 256'(0));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
